// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter
//   Round-robin arbiter that shares one Avalon-MM slave port between
//   NUM_MASTERS requesters. A grant is held through the slave read latency so
//   returning readdata is routed to the master that issued the read, and a
//   per-grant cycle limit forces release of a stuck requester.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   m_chipselect/read/write  per-master request and strobes
//   m_address, m_writedata   packed per-master command, master i at slice i
//   m_readdata               packed per-master routed readdata
//   m_grant                  one-hot grant
//   avslave_*                muxed command to / readdata from the slave
//   busy                     arbiter is serving or releasing a grant
//   timeout                  one-cycle pulse on a forced release
module avalon_bus_arbiter #(
    parameter int NUM_MASTERS  = 4,
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32,
    parameter int READ_LATENCY = 2,
    parameter int MAX_GRANT    = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_chipselect,
    input  logic [NUM_MASTERS-1:0]            m_read,
    input  logic [NUM_MASTERS-1:0]            m_write,
    input  logic [NUM_MASTERS*ADDRESS_SIZE-1:0] m_address,
    input  logic [NUM_MASTERS*DATA_SIZE-1:0]  m_writedata,
    output logic [NUM_MASTERS*DATA_SIZE-1:0]  m_readdata,
    output logic [NUM_MASTERS-1:0]            m_grant,
    output logic                              avslave_chipselect,
    output logic                              avslave_read,
    output logic                              avslave_write,
    output logic [ADDRESS_SIZE-1:0]           avslave_address,
    output logic [DATA_SIZE-1:0]              avslave_writedata,
    input  logic [DATA_SIZE-1:0]              avslave_readdata,
    output logic                              busy,
    output logic                              timeout
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [15:0] GRANT_LAST = 16'(MAX_GRANT - 1);
    localparam logic [7:0]  DRAIN_LAST = (READ_LATENCY > 0) ? 8'(READ_LATENCY - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_DRAIN,
        ST_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [15:0]      gcount_q, gcount_d;
    logic [7:0]       dcount_q, dcount_d;
    logic             rd_seen_q, rd_seen_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             hold_grant;
    logic             sel_cs;
    logic             rd_any;

    logic [ADDRESS_SIZE-1:0] addr_arr  [NUM_MASTERS];
    logic [DATA_SIZE-1:0]    wdata_arr [NUM_MASTERS];

    // Grant is visible while commanding and while draining read data.
    assign hold_grant = (state_q == ST_GRANT) || (state_q == ST_DRAIN);

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
        assign addr_arr[i]  = m_address[i*ADDRESS_SIZE +: ADDRESS_SIZE];
        assign wdata_arr[i] = m_writedata[i*DATA_SIZE +: DATA_SIZE];
        assign m_grant[i]   = hold_grant && (grant_idx_q == IDX_W'(i));
        assign m_readdata[i*DATA_SIZE +: DATA_SIZE] =
            (hold_grant && (grant_idx_q == IDX_W'(i))) ? avslave_readdata : '0;
    end

    // Command pass-through: strobes are qualified by the granted chipselect,
    // and address/data are zeroed whenever chipselect is low.
    assign sel_cs             = (state_q == ST_GRANT) && m_chipselect[grant_idx_q];
    assign avslave_chipselect = sel_cs;
    assign avslave_read       = sel_cs && m_read[grant_idx_q];
    assign avslave_write      = sel_cs && m_write[grant_idx_q];
    assign avslave_address    = sel_cs ? addr_arr[grant_idx_q]  : '0;
    assign avslave_writedata  = sel_cs ? wdata_arr[grant_idx_q] : '0;
    assign busy               = (state_q != ST_IDLE);

    // A read issued on the exit cycle itself still needs its data drained.
    assign rd_any = rd_seen_q || avslave_read;

    // Round-robin pick: first requester after the previous owner.
    always_comb begin
        pick_idx   = last_idx_q;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            int cand;
            cand = (int'(last_idx_q) + k) % NUM_MASTERS;
            if (!pick_found && m_chipselect[cand]) begin
                pick_idx   = IDX_W'(cand);
                pick_found = 1'b1;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        gcount_d    = gcount_q;
        dcount_d    = dcount_q;
        rd_seen_d   = rd_seen_q;
        timeout     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_idx_d = pick_idx;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gcount_d  = gcount_q + 16'd1;
                rd_seen_d = rd_any;
                if (!m_chipselect[grant_idx_q] || (gcount_q == GRANT_LAST)) begin
                    timeout  = m_chipselect[grant_idx_q];
                    dcount_d = 8'd0;
                    state_d  = (rd_any && (READ_LATENCY > 0)) ? ST_DRAIN : ST_RELEASE;
                end
            end
            ST_DRAIN: begin
                dcount_d = dcount_q + 8'd1;
                if (dcount_q == DRAIN_LAST) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                last_idx_d = grant_idx_q;
                gcount_d   = 16'd0;
                dcount_d   = 8'd0;
                rd_seen_d  = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= IDX_W'(NUM_MASTERS - 1);
            gcount_q    <= '0;
            dcount_q    <= '0;
            rd_seen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            gcount_q    <= gcount_d;
            dcount_q    <= dcount_d;
            rd_seen_q   <= rd_seen_d;
        end
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb_avalon_bus_arbiter
//   Self-checking bench for avalon_bus_arbiter. A cycle-level behavioural
//   model derived from the arbitration rules predicts every output at each
//   falling edge; directed scenarios add literal expectations on grant
//   order, grant lengths, timeout pulses and readdata routing.
module tb_avalon_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int MG = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    m_chipselect, m_read, m_write;
    logic [N*AW-1:0] m_address;
    logic [N*DW-1:0] m_writedata;
    logic [N*DW-1:0] m_readdata;
    logic [N-1:0]    m_grant;
    logic            avslave_chipselect, avslave_read, avslave_write;
    logic [AW-1:0]   avslave_address;
    logic [DW-1:0]   avslave_writedata;
    logic [DW-1:0]   avslave_readdata;
    logic            busy, timeout;

    // Per-master stimulus, packed onto the DUT buses below.
    logic          cs_a [N];
    logic          rd_a [N];
    logic          wr_a [N];
    logic [AW-1:0] ad_a [N];
    logic [DW-1:0] wd_a [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            m_chipselect[i]           = cs_a[i];
            m_read[i]                 = rd_a[i];
            m_write[i]                = wr_a[i];
            m_address[i*AW +: AW]     = ad_a[i];
            m_writedata[i*DW +: DW]   = wd_a[i];
        end
    end

    // Slave responder: DEADBEEF RL cycles after a read, background otherwise.
    logic [1:0] rd_pipe = 2'b00;
    always @(posedge clk) rd_pipe <= {rd_pipe[0], avslave_read};
    assign avslave_readdata = rd_pipe[1] ? 32'hDEAD_BEEF : 32'h1234_5678;

    always #5 clk = ~clk;

    avalon_bus_arbiter #(
        .NUM_MASTERS (N),
        .ADDRESS_SIZE(AW),
        .DATA_SIZE   (DW),
        .READ_LATENCY(RL),
        .MAX_GRANT   (MG)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .m_chipselect      (m_chipselect),
        .m_read            (m_read),
        .m_write           (m_write),
        .m_address         (m_address),
        .m_writedata       (m_writedata),
        .m_readdata        (m_readdata),
        .m_grant           (m_grant),
        .avslave_chipselect(avslave_chipselect),
        .avslave_read      (avslave_read),
        .avslave_write     (avslave_write),
        .avslave_address   (avslave_address),
        .avslave_writedata (avslave_writedata),
        .avslave_readdata  (avslave_readdata),
        .busy              (busy),
        .timeout           (timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model and per-cycle compare ----------------
    bit   model_on     = 1'b0;
    int   mdl_owner    = -1;   // master holding the bus, -1 when none
    int   mdl_last     = N - 1;
    int   mdl_granted  = 0;    // commanding cycles used by the current owner
    bit   mdl_saw_read = 1'b0;
    int   mdl_hold_end = -1;   // last cycle the grant stays visible; -1 while commanding
    int   mdl_cyc      = 0;

    logic [N-1:0]    e_grant;
    logic            e_cs, e_rd, e_wr, e_busy, e_to, exit_now;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wdata;
    logic [N*DW-1:0] e_rdata;

    // Observation logs written only by the compare process.
    int   gl_idx [$];
    int   gl_len [$];
    logic [N-1:0] prev_grant = '0;
    int   run_len  = 0;
    int   slv_hits = 0;
    int   rd_hits  = 0;
    int   to_cnt   = 0;
    int   busy_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                e_grant = '0; e_cs = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
                e_rdata = '0; e_busy = 0; e_to = 0; exit_now = 0;
                if (mdl_owner >= 0) begin
                    e_busy = 1'b1;
                    if (mdl_hold_end < 0) begin
                        e_grant[mdl_owner] = 1'b1;
                        e_rdata[mdl_owner*DW +: DW] = avslave_readdata;
                        if (cs_a[mdl_owner]) begin
                            e_cs    = 1'b1;
                            e_rd    = rd_a[mdl_owner];
                            e_wr    = wr_a[mdl_owner];
                            e_addr  = ad_a[mdl_owner];
                            e_wdata = wd_a[mdl_owner];
                        end
                        e_to     = cs_a[mdl_owner] && (mdl_granted == MG - 1);
                        exit_now = !cs_a[mdl_owner] || e_to;
                    end else if (mdl_cyc <= mdl_hold_end) begin
                        e_grant[mdl_owner] = 1'b1;
                        e_rdata[mdl_owner*DW +: DW] = avslave_readdata;
                    end
                end

                check("m_grant",    128'(m_grant),            128'(e_grant));
                check("slv_cs",     128'(avslave_chipselect), 128'(e_cs));
                check("slv_read",   128'(avslave_read),       128'(e_rd));
                check("slv_write",  128'(avslave_write),      128'(e_wr));
                check("slv_addr",   128'(avslave_address),    128'(e_addr));
                check("slv_wdata",  128'(avslave_writedata),  128'(e_wdata));
                check("m_readdata", 128'(m_readdata),         128'(e_rdata));
                check("busy",       128'(busy),               128'(e_busy));
                check("timeout",    128'(timeout),            128'(e_to));

                // Advance the model to the next cycle.
                if (reset) begin
                    mdl_owner    = -1;
                    mdl_last     = N - 1;
                    mdl_hold_end = -1;
                end else if (mdl_owner >= 0) begin
                    if (mdl_hold_end < 0) begin
                        mdl_granted++;
                        mdl_saw_read = mdl_saw_read | e_rd;
                        if (exit_now)
                            mdl_hold_end = mdl_cyc + ((mdl_saw_read && RL > 0) ? RL : 0);
                    end else if (mdl_cyc > mdl_hold_end) begin
                        mdl_last  = mdl_owner;
                        mdl_owner = -1;
                    end
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        int j;
                        j = (mdl_last + k) % N;
                        if (mdl_owner < 0 && cs_a[j]) mdl_owner = j;
                    end
                    mdl_granted  = 0;
                    mdl_saw_read = 1'b0;
                    mdl_hold_end = -1;
                end

                // Observations of the DUT for the directed literal checks.
                if (m_grant != '0) begin
                    if (prev_grant == '0) begin
                        for (int i = 0; i < N; i++) if (m_grant[i]) gl_idx.push_back(i);
                        run_len = 0;
                    end
                    run_len++;
                end else if (prev_grant != '0) begin
                    gl_len.push_back(run_len);
                end
                prev_grant = m_grant;
                if (avslave_chipselect && avslave_address == 32'h10 && avslave_writedata == 32'hA5)
                    slv_hits++;
                if (m_grant == 4'b0010 && m_readdata == 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000)
                    rd_hits++;
                if (timeout) to_cnt++;
                if (busy) busy_cnt++;
            end
            mdl_cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Request, wait for n granted cycles, then drop the request.
    task automatic run_master(input int idx, input int n, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input bit is_read);
        int got;
        int waited;
        got = 0;
        waited = 0;
        @(posedge clk); #1;
        cs_a[idx] = 1'b1; rd_a[idx] = is_read; wr_a[idx] = !is_read;
        ad_a[idx] = addr; wd_a[idx] = data;
        while (got < n && waited < 1000) begin
            @(negedge clk);
            if (m_grant[idx]) got++;
            waited++;
        end
        check("grant_wait", 128'(got), 128'(n));
        @(posedge clk); #1;
        cs_a[idx] = 1'b0; rd_a[idx] = 1'b0; wr_a[idx] = 1'b0; ad_a[idx] = '0; wd_a[idx] = '0;
    endtask

    // Hold a write request for a fixed number of cycles regardless of grant.
    task automatic hold_cycles(input int idx, input int n);
        @(posedge clk); #1;
        cs_a[idx] = 1'b1; wr_a[idx] = 1'b1; ad_a[idx] = 32'h200; wd_a[idx] = 32'h77;
        repeat (n) @(posedge clk);
        #1;
        cs_a[idx] = 1'b0; wr_a[idx] = 1'b0; ad_a[idx] = '0; wd_a[idx] = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, h0, b0, t0, w;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            cs_a[i] = 0; rd_a[i] = 0; wr_a[i] = 0; ad_a[i] = '0; wd_a[i] = '0;
        end
        @(posedge clk); #1 model_on = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_grant",    128'(m_grant), 128'(0));
        check("rst_busy",     128'(busy), 128'(0));
        check("rst_readdata", 128'(m_readdata), 128'(0));
        check("rst_slv_cs",   128'(avslave_chipselect), 128'(0));
        #1 reset = 1'b0;

        // 1: single master 2 write
        g0 = gl_idx.size(); h0 = slv_hits;
        fork
            run_master(2, 3, 32'h10, 32'hA5, 1'b0);
            begin
                @(posedge clk); #1;
                @(negedge clk) check("t1_no_grant_yet", 128'(m_grant), 128'(0));
                @(negedge clk) check("t1_grant", 128'(m_grant), 128'(4'b0100));
            end
        join
        repeat (4) @(negedge clk);
        check("t1_slave_cycles", 128'(slv_hits - h0), 128'(3));
        check("t1_owner", 128'(gl_idx[g0]), 128'(2));
        check("t1_len", 128'(gl_len[g0]), 128'(4));
        check("t1_busy_after", 128'(busy), 128'(0));

        // 2: all four request together
        do_reset();
        g0 = gl_idx.size();
        fork
            begin
                run_master(0, 4, 32'h100, 32'h1, 1'b0);
                run_master(0, 4, 32'h104, 32'h5, 1'b0);
            end
            run_master(1, 4, 32'h110, 32'h2, 1'b0);
            run_master(2, 4, 32'h120, 32'h3, 1'b0);
            run_master(3, 4, 32'h130, 32'h4, 1'b0);
        join
        repeat (4) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("t2_order", 128'(gl_idx[g0+k]), 128'(exp_order[k]));
            check("t2_len", 128'(gl_len[g0+k]), 128'(5));
        end

        // 3: master 1 read with drain
        g0 = gl_idx.size(); h0 = rd_hits;
        run_master(1, 1, 32'h40, 32'h0, 1'b1);
        repeat (6) @(negedge clk);
        check("t3_routed", 128'(rd_hits - h0), 128'(1));
        check("t3_owner", 128'(gl_idx[g0]), 128'(1));
        check("t3_len_with_drain", 128'(gl_len[g0]), 128'(4));

        // 4: stuck master 0, master 3 waiting
        g0 = gl_idx.size(); t0 = to_cnt;
        fork
            hold_cycles(0, 100);
            begin
                repeat (5) @(posedge clk);
                run_master(3, 2, 32'h300, 32'h33, 1'b0);
            end
        join
        repeat (5) @(negedge clk);
        check("t4_timeouts", 128'(to_cnt - t0), 128'(1));
        check("t4_owner", 128'(gl_idx[g0]), 128'(0));
        check("t4_len", 128'(gl_len[g0]), 128'(MG));
        check("t4_next", 128'(gl_idx[g0+1]), 128'(3));

        // 5: reset during drain
        fork
            run_master(1, 1, 32'h80, 32'h0, 1'b1);
            begin
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!m_grant[1] && w < 1000);
                check("t5_wait", 128'(m_grant[1]), 128'(1));
                @(posedge clk); #1;
                @(posedge clk); #1 reset = 1'b1;
                @(posedge clk); #1 reset = 1'b0;
            end
        join
        @(negedge clk);
        check("t5_grant", 128'(m_grant), 128'(0));
        check("t5_busy", 128'(busy), 128'(0));
        check("t5_readdata", 128'(m_readdata), 128'(0));
        check("t5_slv_cs", 128'(avslave_chipselect), 128'(0));
        g0 = gl_idx.size();
        fork
            run_master(0, 1, 32'h400, 32'h1, 1'b0);
            run_master(1, 1, 32'h410, 32'h2, 1'b0);
            run_master(2, 1, 32'h420, 32'h3, 1'b0);
            run_master(3, 1, 32'h430, 32'h4, 1'b0);
        join
        repeat (20) @(negedge clk);
        check("t5_first_after_reset", 128'(gl_idx[g0]), 128'(0));

        // 6: read strobe without chipselect
        g0 = gl_idx.size(); b0 = busy_cnt;
        @(posedge clk); #1 rd_a[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rd_a[2] = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_no_grant", 128'(gl_idx.size()), 128'(g0));
        check("t6_not_busy", 128'(busy_cnt - b0), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
